// File: rtl/hazard_ctrl.sv
// ID/EX hazard sequencer for the RV32I pipeline: load-use stall, redirect flush, and forwarding selects.
// Zero-latency outputs from the EX/MEM shadows. Define HAZARD_PERF_EN to add saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic                  rs1_alu_loopback,
  output logic                  rs2_alu_loopback,
  output logic                  rs1_mem_loopback,
  output logic                  rs2_mem_loopback
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic                  is_load;
  } shadow_t;

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  shadow_t    ex_q, mem_q;
  state_t     state;
  logic [3:0] cnt;

  function automatic logic hit(shadow_t s, logic [REG_ADDR_W-1:0] addr, logic used, logic vld);
    return s.valid & s.wb_en & (s.rd != '0) & used & (s.rd == addr) & vld;
  endfunction

  logic in_flush, idv;
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, load_use;

  assign in_flush = (state == FLUSH);
  assign idv      = id_valid & ~in_flush;
  assign ex_hit1  = hit(ex_q,  id_rs1_addr, id_rs1_used, idv);
  assign ex_hit2  = hit(ex_q,  id_rs2_addr, id_rs2_used, idv);
  assign mem_hit1 = hit(mem_q, id_rs1_addr, id_rs1_used, idv);
  assign mem_hit2 = hit(mem_q, id_rs2_addr, id_rs2_used, idv);
  assign load_use = (ex_hit1 | ex_hit2) & ex_q.is_load;

  always_comb begin
    stall_if_id      = 1'b0;
    flush_if_id      = 1'b0;
    bubble_id_ex     = 1'b0;
    rs1_alu_loopback = 1'b0;
    rs2_alu_loopback = 1'b0;
    rs1_mem_loopback = 1'b0;
    rs2_mem_loopback = 1'b0;
    if (rst || ex_redirect || in_flush) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (load_use) begin
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else begin
      // An EX hit here is never a load, so it always wins over an older MEM value.
      rs1_alu_loopback = ex_hit1;
      rs2_alu_loopback = ex_hit2;
      rs1_mem_loopback = mem_hit1 & ~ex_hit1;
      rs2_mem_loopback = mem_hit2 & ~ex_hit2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      mem_q <= ex_q;
      if (bubble_id_ex) ex_q <= '0;
      else              ex_q <= '{valid: id_valid, rd: id_rd_addr, wb_en: id_wb_en, is_load: id_is_load};
      if (ex_redirect) begin
        state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        cnt   <= CNT_INIT;
      end else if (in_flush) begin
        if (cnt == 4'd0) state <= RUN;
        else             cnt   <= cnt - 4'd1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if_id && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_if_id && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (FLUSH_CYCLES=3); expected outputs queued per cycle, checked by a monitor.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_wb_en, id_is_load, ex_redirect;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       stall_if_id, flush_if_id, bubble_id_ex;
  logic       rs1_alu_loopback, rs2_alu_loopback, rs1_mem_loopback, rs2_mem_loopback;

  int total = 0;
  int bad   = 0;

  string      name_q[$];
  logic [6:0] exp_q[$];

  // {stall, flush, bubble, rs1_alu, rs2_alu, rs1_mem, rs2_mem}
  localparam logic [6:0] N   = 7'b0000000;
  localparam logic [6:0] RB  = 7'b0110000;
  localparam logic [6:0] STB = 7'b1010000;

  hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .rs1_alu_loopback(rs1_alu_loopback), .rs2_alu_loopback(rs2_alu_loopback),
    .rs1_mem_loopback(rs1_mem_loopback), .rs2_mem_loopback(rs2_mem_loopback)
  );

  always #5 clk = ~clk;

  // Monitor: the DUT presents a fresh output vector every cycle; check it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string      nm;
      logic [6:0] want, got;
      nm   = name_q.pop_front();
      want = exp_q.pop_front();
      got  = {stall_if_id, flush_if_id, bubble_id_ex, rs1_alu_loopback, rs2_alu_loopback,
              rs1_mem_loopback, rs2_mem_loopback};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got=%b want=%b (stall,flush,bubble,a1,a2,m1,m2)", nm, got, want);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic v,
                     input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                     input logic [4:0] rd, input logic wb, input logic ld, input logic rdr,
                     input logic [6:0] want);
    @(posedge clk);
    #1;
    rst = r; id_valid = v;
    id_rs1_addr = a1; id_rs1_used = u1; id_rs2_addr = a2; id_rs2_used = u2;
    id_rd_addr = rd; id_wb_en = wb; id_is_load = ld; ex_redirect = rdr;
    name_q.push_back(nm);
    exp_q.push_back(want);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs1_addr = '0; id_rs1_used = 1'b0; id_rs2_addr = '0;
    id_rs2_used = 1'b0; id_rd_addr = '0; id_wb_en = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;
    //   name          rst v  rs1 u  rs2 u  rd  wb ld rdr  expected
    cyc("reset0",      1, 1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0, 0, RB);
    cyc("reset1",      1, 1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 1, RB);
    // add x5 then add x6,x5,x1
    cyc("t1_prod",     0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, N);
    cyc("t1_alu_fwd",  0, 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 7'b0001000);
    // add x5; nop; sub x7,x1,x5
    cyc("t2_prod",     0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, N);
    cyc("t2_nop",      0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, N);
    cyc("t2_mem_fwd",  0, 1, 5'd1, 1, 5'd5, 1, 5'd7, 1, 0, 0, 7'b0000001);
    // lw x5 then add x6,x5,x5 (re-presented after stall)
    cyc("t3_load",     0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, N);
    cyc("t3_stall",    0, 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, STB);
    cyc("t3_after",    0, 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 7'b0000011);
    // writes to x0 (including a load) never hit
    cyc("t4_addi_x0",  0, 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, N);
    cyc("t4_lw_x0",    0, 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, N);
    cyc("t4_rd_x0",    0, 1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0, N);
    // used flags, EX/MEM on different and same registers, id_valid=0
    cyc("unused_rs1",  0, 1, 5'd1, 0, 5'd1, 1, 5'd3, 1, 0, 0, 7'b0000100);
    cyc("ex_and_mem",  0, 1, 5'd3, 1, 5'd1, 1, 5'd3, 1, 0, 0, 7'b0001001);
    cyc("ex_prio",     0, 1, 5'd3, 1, 5'd0, 0, 5'd8, 1, 0, 0, 7'b0001000);
    cyc("id_invalid",  0, 0, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, N);
    cyc("inv_no_shdw", 0, 1, 5'd9, 1, 5'd8, 1, 5'd0, 0, 0, 0, 7'b0000001);
    // single redirect: exactly 3 flush cycles
    cyc("redir1_c0",   0, 1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 1, RB);
    cyc("redir1_c1",   0, 1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 0, 0, RB);
    cyc("redir1_c2",   0, 1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 0, 0, RB);
    cyc("redir1_run",  0, 1, 5'd0, 1, 5'd0, 0, 5'd11, 1, 1, 0, N);
    // redirect beats load-use; second pulse in 2nd flush cycle -> 4 total
    cyc("redir_lu",    0, 1, 5'd11, 1, 5'd0, 0, 5'd6, 1, 0, 1, RB);
    cyc("redir2_c1",   0, 1, 5'd11, 1, 5'd0, 0, 5'd6, 1, 0, 1, RB);
    cyc("redir2_c2",   0, 1, 5'd11, 1, 5'd0, 0, 5'd6, 1, 0, 0, RB);
    cyc("redir2_c3",   0, 1, 5'd11, 1, 5'd0, 0, 5'd6, 1, 0, 0, RB);
    cyc("redir2_run",  0, 1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, N);
    // reset in the middle of a flush
    cyc("rst_flush0",  0, 1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 1, RB);
    cyc("rst_flush1",  1, 1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, RB);
    cyc("rst_release", 0, 1, 5'd12, 1, 5'd11, 1, 5'd14, 1, 0, 0, N);
    cyc("rst_after",   0, 1, 5'd14, 1, 5'd2, 1, 5'd0, 0, 0, 0, 7'b0001000);
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
